// File: rtl/mem_req_router.sv
// Multi-channel memory request router: arbitrates channel requests onto one
// memory port, tags access_id with the channel, and routes responses back by tag.
module mem_req_router #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ID_W     = 8,
  parameter int unsigned MAX_OUT  = 16,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req_vld,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_req_data,
  input  logic [NUM_CH-1:0][ID_W-1:0]    ch_req_id,
  output logic [NUM_CH-1:0]              ch_req_rdy,
  output logic                           mem_req_vld,
  output logic [DATA_W-1:0]              mem_req_data,
  output logic [ID_W-1:0]                mem_req_id,
  input  logic                           mem_req_rdy,
  input  logic                           mem_rsp_vld,
  input  logic [DATA_W-1:0]              mem_rsp_data,
  input  logic [ID_W-1:0]                mem_rsp_id,
  output logic [NUM_CH-1:0]              ch_rsp_vld,
  output logic [DATA_W-1:0]              ch_rsp_data,
  output logic [ID_W-1:0]                ch_rsp_id,
  output logic [NUM_CH-1:0][7:0]         ch_outstanding,
  output logic                           rsp_err
);

  logic                      mem_req_vld_q, mem_req_vld_d;
  logic [DATA_W-1:0]         mem_req_data_q, mem_req_data_d;
  logic [ID_W-1:0]           mem_req_id_q, mem_req_id_d;
  logic [NUM_CH-1:0]         ch_rsp_vld_q, ch_rsp_vld_d;
  logic [DATA_W-1:0]         ch_rsp_data_q, ch_rsp_data_d;
  logic [ID_W-1:0]           ch_rsp_id_q, ch_rsp_id_d;
  logic [NUM_CH-1:0][7:0]    cnt_q, cnt_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0]         elig;
  logic                      free;
  logic                      found;
  logic                      gnt_vld;
  logic [CH_W-1:0]           gnt_idx;
  logic [NUM_CH-1:0]         gnt_oh;
  int unsigned               cand;
  logic [CH_W-1:0]           rsp_ch;
  logic [NUM_CH-1:0]         rsp_hit;
  logic                      rsp_drop;
  logic                      unused_id_bits;

  // Eligibility and winner selection; the last match in a descending scan is the first in priority order
  always_comb begin
    free           = !mem_req_vld_q || mem_req_rdy;
    found          = 1'b0;
    gnt_idx        = '0;
    cand           = 0;
    unused_id_bits = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      elig[i]        = ch_req_vld[i] && (cnt_q[i] < 8'(MAX_OUT));
      unused_id_bits = unused_id_bits ^ (^ch_req_id[i][ID_W-1 -: CH_W]);
    end
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        cand = 32'(k);
      end else begin
        cand = 32'(rr_ptr_q) + 32'(k);
        if (cand >= NUM_CH) cand = cand - NUM_CH;
      end
      if (elig[CH_W'(cand)]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
    gnt_vld = found && free && !reset;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == CH_W'(i));
    end
  end

  assign ch_req_rdy = gnt_oh;

  // Next-state for request register, response routing, counters and pointer
  always_comb begin
    mem_req_vld_d  = mem_req_vld_q;
    mem_req_data_d = mem_req_data_q;
    mem_req_id_d   = mem_req_id_q;
    ch_rsp_data_d  = ch_rsp_data_q;
    ch_rsp_id_d    = ch_rsp_id_q;
    rr_ptr_d       = rr_ptr_q;

    if (gnt_vld) begin
      mem_req_vld_d  = 1'b1;
      mem_req_data_d = ch_req_data[gnt_idx];
      mem_req_id_d   = {gnt_idx, ch_req_id[gnt_idx][ID_W-CH_W-1:0]};
      rr_ptr_d       = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end else if (mem_req_rdy) begin
      mem_req_vld_d  = 1'b0;
    end

    rsp_ch = mem_rsp_id[ID_W-1 -: CH_W];
    for (int i = 0; i < int'(NUM_CH); i++) begin
      rsp_hit[i] = mem_rsp_vld && (rsp_ch == CH_W'(i)) && (cnt_q[i] != 8'd0);
      cnt_d[i]   = cnt_q[i] + 8'(gnt_oh[i]) - 8'(rsp_hit[i]);
    end
    rsp_drop     = mem_rsp_vld && !(|rsp_hit);
    ch_rsp_vld_d = rsp_hit;
    if (|rsp_hit) begin
      ch_rsp_data_d = mem_rsp_data;
      ch_rsp_id_d   = mem_rsp_id;
    end
    rsp_err_d = rsp_err_q || rsp_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_vld_q  <= 1'b0;
      mem_req_data_q <= '0;
      mem_req_id_q   <= '0;
      ch_rsp_vld_q   <= '0;
      ch_rsp_data_q  <= '0;
      ch_rsp_id_q    <= '0;
      cnt_q          <= '0;
      rsp_err_q      <= 1'b0;
      rr_ptr_q       <= '0;
    end else begin
      mem_req_vld_q  <= mem_req_vld_d;
      mem_req_data_q <= mem_req_data_d;
      mem_req_id_q   <= mem_req_id_d;
      ch_rsp_vld_q   <= ch_rsp_vld_d;
      ch_rsp_data_q  <= ch_rsp_data_d;
      ch_rsp_id_q    <= ch_rsp_id_d;
      cnt_q          <= cnt_d;
      rsp_err_q      <= rsp_err_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign mem_req_vld    = mem_req_vld_q;
  assign mem_req_data   = mem_req_data_q;
  assign mem_req_id     = mem_req_id_q;
  assign ch_rsp_vld     = ch_rsp_vld_q;
  assign ch_rsp_data    = ch_rsp_data_q;
  assign ch_rsp_id      = ch_rsp_id_q;
  assign ch_outstanding = cnt_q;
  assign rsp_err        = rsp_err_q;

endmodule
